// File: rtl/access_log_writer.sv
// Purpose: buffers GDP access events in a small FIFO and writes them as {type, addr} entries to consecutive log BRAM addresses.
// Latency: an event sampled at edge N into an empty FIFO pops in cycle N+1 and strobes log_wr from edge N+1 (one cycle).
// Backpressure: log_busy stalls the pop with the head held; a full FIFO drops new events and sets sticky overflow.
module access_log_writer #(
    parameter int LOG_AW     = 10,
    parameter int FIFO_DEPTH = 4,
    parameter int WRAP       = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              clear,
    input  logic              ev_valid,
    input  logic              ev_write,
    input  logic [15:0]       ev_addr,
    input  logic              log_busy,
    output logic              log_wr,
    output logic [LOG_AW-1:0] log_addr,
    output logic [23:0]       log_data,
    output logic [LOG_AW:0]   entry_count,
    output logic              log_full,
    output logic              overflow
);

    localparam int FAW = $clog2(FIFO_DEPTH);
    localparam logic [LOG_AW:0] CNT_MAX  = {1'b1, {LOG_AW{1'b0}}};
    localparam logic [LOG_AW:0] CNT_LAST = CNT_MAX - (LOG_AW+1)'(1);
    localparam logic [FAW:0]    FIFO_FULL_CNT = {1'b1, {FAW{1'b0}}};

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [LOG_AW-1:0]   wptr_q, wptr_d;
    logic [LOG_AW:0]     cnt_q, cnt_d;
    logic                full_q, full_d;
    logic                ovf_q, ovf_d;
    logic                wr_q, wr_d;
    logic [LOG_AW-1:0]   addr_q, addr_d;
    logic [23:0]         data_q, data_d;
    logic [FAW-1:0]      fifo_rd_q, fifo_rd_d;
    logic [FAW-1:0]      fifo_wr_q, fifo_wr_d;
    logic [FAW:0]        fifo_cnt_q, fifo_cnt_d;
    logic [23:0]         fifo_mem_q [FIFO_DEPTH];

    logic                fifo_empty;
    logic                fifo_full;
    logic                push_req;
    logic                push;
    logic                pop;
    logic [23:0]         ev_entry;
    logic [23:0]         head;

    assign fifo_empty = (fifo_cnt_q == '0);
    assign fifo_full  = (fifo_cnt_q == FIFO_FULL_CNT);
    assign head       = fifo_mem_q[fifo_rd_q];
    assign ev_entry   = {(ev_write ? 8'h01 : 8'h02), ev_addr};

    // Pop only while running and the BRAM port is free; a same-cycle pop frees a slot for the push.
    always_comb begin
        pop      = !clear && (state_q == ST_RUN) && !fifo_empty && !log_busy;
        push_req = ev_valid && enable && !clear;
        push     = push_req && (!fifo_full || pop);
    end

    // Next-state for FIFO pointers, log pointers, counters, flags and the registered write port.
    always_comb begin
        state_d    = state_q;
        wptr_d     = wptr_q;
        cnt_d      = cnt_q;
        full_d     = full_q;
        ovf_d      = ovf_q;
        wr_d       = pop;
        addr_d     = addr_q;
        data_d     = data_q;
        fifo_rd_d  = fifo_rd_q;
        fifo_wr_d  = fifo_wr_q;
        fifo_cnt_d = fifo_cnt_q;

        if (clear) begin
            state_d    = ST_RUN;
            wptr_d     = '0;
            cnt_d      = '0;
            full_d     = 1'b0;
            ovf_d      = 1'b0;
            wr_d       = 1'b0;
            fifo_rd_d  = '0;
            fifo_wr_d  = '0;
            fifo_cnt_d = '0;
        end else begin
            if (push_req && !push) begin
                ovf_d = 1'b1;
            end
            if (push) begin
                fifo_wr_d = fifo_wr_q + FAW'(1);
            end
            if (pop) begin
                fifo_rd_d = fifo_rd_q + FAW'(1);
                addr_d    = wptr_q;
                data_d    = head;
                wptr_d    = wptr_q + LOG_AW'(1);
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + (LOG_AW+1)'(1);
                end
                if (cnt_q == CNT_LAST) begin
                    full_d = 1'b1;
                    if (WRAP == 0) begin
                        state_d = ST_HALT;
                    end
                end
            end
            case ({push, pop})
                2'b10:   fifo_cnt_d = fifo_cnt_q + (FAW+1)'(1);
                2'b01:   fifo_cnt_d = fifo_cnt_q - (FAW+1)'(1);
                default: fifo_cnt_d = fifo_cnt_q;
            endcase
        end
    end

    // Control state, counters and the registered BRAM write port, with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RUN;
            wptr_q     <= '0;
            cnt_q      <= '0;
            full_q     <= 1'b0;
            ovf_q      <= 1'b0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            fifo_rd_q  <= '0;
            fifo_wr_q  <= '0;
            fifo_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wptr_q     <= wptr_d;
            cnt_q      <= cnt_d;
            full_q     <= full_d;
            ovf_q      <= ovf_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            fifo_rd_q  <= fifo_rd_d;
            fifo_wr_q  <= fifo_wr_d;
            fifo_cnt_q <= fifo_cnt_d;
        end
    end

    // Event storage; contents are only meaningful between the pointers, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[fifo_wr_q] <= ev_entry;
        end
    end

    assign log_wr      = wr_q;
    assign log_addr    = addr_q;
    assign log_data    = data_q;
    assign entry_count = cnt_q;
    assign log_full    = full_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_access_log_writer.sv
// Directed bench for access_log_writer: two LOG_AW=3 instances share stimulus, one stopping when full, one wrapping.
// Inputs change 1ns after the rising edge; outputs are checked there and strobes are logged on the falling edge.
// Each scenario task checks its own expectations and the initial block prints one summary line.
module tb_access_log_writer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        clear = 1'b0;
    logic        ev_valid = 1'b0;
    logic        ev_write = 1'b0;
    logic [15:0] ev_addr = 16'h0000;
    logic        log_busy = 1'b0;

    logic        log_wr0, log_wr1;
    logic [2:0]  log_addr0, log_addr1;
    logic [23:0] log_data0, log_data1;
    logic [3:0]  entry_count0, entry_count1;
    logic        log_full0, log_full1;
    logic        overflow0, overflow1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [2:0]  a0_q [$];
    logic [23:0] d0_q [$];
    int          c0_q [$];
    logic [2:0]  a1_q [$];
    logic [23:0] d1_q [$];

    access_log_writer #(.LOG_AW(3), .FIFO_DEPTH(4), .WRAP(0)) dut0 (
        .clk(clk), .rst(rst), .enable(enable), .clear(clear),
        .ev_valid(ev_valid), .ev_write(ev_write), .ev_addr(ev_addr), .log_busy(log_busy),
        .log_wr(log_wr0), .log_addr(log_addr0), .log_data(log_data0),
        .entry_count(entry_count0), .log_full(log_full0), .overflow(overflow0)
    );

    access_log_writer #(.LOG_AW(3), .FIFO_DEPTH(4), .WRAP(1)) dut1 (
        .clk(clk), .rst(rst), .enable(enable), .clear(clear),
        .ev_valid(ev_valid), .ev_write(ev_write), .ev_addr(ev_addr), .log_busy(log_busy),
        .log_wr(log_wr1), .log_addr(log_addr1), .log_data(log_data1),
        .entry_count(entry_count1), .log_full(log_full1), .overflow(overflow1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe log for both instances, sampled mid-cycle.
    always @(negedge clk) begin
        if (log_wr0) begin
            a0_q.push_back(log_addr0);
            d0_q.push_back(log_data0);
            c0_q.push_back(cyc);
        end
        if (log_wr1) begin
            a1_q.push_back(log_addr1);
            d1_q.push_back(log_data1);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic w, input logic [15:0] a);
        ev_valid = 1'b1;
        ev_write = w;
        ev_addr  = a;
        tick(1);
        ev_valid = 1'b0;
    endtask

    task automatic do_reset;
        rst = 1'b1; enable = 1'b0; clear = 1'b0; ev_valid = 1'b0; log_busy = 1'b0;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick(2);
        checks++; if (log_wr0 !== 1'b0) begin errors++; $display("FAIL reset_log_wr: got %b expected 0", log_wr0); end
        checks++; if (log_addr0 !== 3'd0) begin errors++; $display("FAIL reset_log_addr: got %h expected 0", log_addr0); end
        checks++; if (log_data0 !== 24'h0) begin errors++; $display("FAIL reset_log_data: got %h expected 0", log_data0); end
        checks++; if (entry_count0 !== 4'd0) begin errors++; $display("FAIL reset_entry_count: got %0d expected 0", entry_count0); end
        checks++; if (log_full0 !== 1'b0) begin errors++; $display("FAIL reset_log_full: got %b expected 0", log_full0); end
        checks++; if (overflow0 !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow0); end
        checks++; if (entry_count1 !== 4'd0) begin errors++; $display("FAIL reset_entry_count_wrap: got %0d expected 0", entry_count1); end
        rst = 1'b0;
        tick(1);
    endtask

    task automatic test_single;
        int b0;
        do_reset();
        enable = 1'b1;
        b0 = a0_q.size();
        pulse(1'b1, 16'h1234);
        checks++; if (log_wr0 !== 1'b0) begin errors++; $display("FAIL single_no_early_strobe: got %b expected 0", log_wr0); end
        tick(1);
        checks++; if (log_wr0 !== 1'b1) begin errors++; $display("FAIL single_strobe: got %b expected 1", log_wr0); end
        checks++; if (log_addr0 !== 3'd0) begin errors++; $display("FAIL single_addr: got %h expected 0", log_addr0); end
        checks++; if (log_data0 !== 24'h011234) begin errors++; $display("FAIL single_data: got %h expected 011234", log_data0); end
        checks++; if (entry_count0 !== 4'd1) begin errors++; $display("FAIL single_count: got %0d expected 1", entry_count0); end
        tick(1);
        checks++; if (log_wr0 !== 1'b0) begin errors++; $display("FAIL single_strobe_one_cycle: got %b expected 0", log_wr0); end
        checks++; if (log_data0 !== 24'h011234) begin errors++; $display("FAIL single_data_hold: got %h expected 011234", log_data0); end
        checks++; if (a0_q.size() - b0 !== 1) begin errors++; $display("FAIL single_strobe_total: got %0d expected 1", a0_q.size() - b0); end
    endtask

    task automatic test_burst_stall;
        int b0, b1;
        do_reset();
        enable = 1'b1;
        log_busy = 1'b1;
        b0 = a0_q.size();
        b1 = a1_q.size();
        for (int i = 0; i < 6; i++) begin
            ev_valid = 1'b1; ev_write = 1'b0; ev_addr = 16'h0100 + 16'(i);
            tick(1);
        end
        ev_valid = 1'b0;
        tick(2);
        checks++; if (overflow0 !== 1'b1) begin errors++; $display("FAIL burst_overflow: got %b expected 1", overflow0); end
        checks++; if (a0_q.size() !== b0) begin errors++; $display("FAIL burst_no_write_while_busy: got %0d expected %0d", a0_q.size(), b0); end
        checks++; if (entry_count0 !== 4'd0) begin errors++; $display("FAIL burst_count_busy: got %0d expected 0", entry_count0); end
        log_busy = 1'b0;
        tick(8);
        checks++; if (a0_q.size() !== b0 + 4) begin errors++; $display("FAIL burst_strobes: got %0d expected %0d", a0_q.size(), b0 + 4); end
        if (a0_q.size() >= b0 + 4) begin
            for (int i = 0; i < 4; i++) begin
                checks++; if (a0_q[b0+i] !== 3'(i)) begin errors++; $display("FAIL burst_addr[%0d]: got %0d expected %0d", i, a0_q[b0+i], i); end
                checks++; if (d0_q[b0+i] !== 24'h020100 + 24'(i)) begin errors++; $display("FAIL burst_data[%0d]: got %h expected %h", i, d0_q[b0+i], 24'h020100 + 24'(i)); end
                checks++; if (c0_q[b0+i] !== c0_q[b0] + i) begin errors++; $display("FAIL back_to_back[%0d]: cycle %0d expected %0d", i, c0_q[b0+i], c0_q[b0] + i); end
            end
        end
        checks++; if (entry_count0 !== 4'd4) begin errors++; $display("FAIL burst_count: got %0d expected 4", entry_count0); end
        checks++; if (overflow0 !== 1'b1) begin errors++; $display("FAIL burst_overflow_sticky: got %b expected 1", overflow0); end
        checks++; if (a1_q.size() !== b1 + 4) begin errors++; $display("FAIL burst_strobes_wrap: got %0d expected %0d", a1_q.size(), b1 + 4); end
    endtask

    task automatic test_full_and_wrap;
        int b0, b1;
        do_reset();
        enable = 1'b1;
        b0 = a0_q.size();
        b1 = a1_q.size();
        for (int i = 0; i < 10; i++) begin
            pulse(1'b1, 16'h1000 + 16'(i));
            tick(2);
        end
        checks++; if (a0_q.size() !== b0 + 8) begin errors++; $display("FAIL full_strobes: got %0d expected %0d", a0_q.size(), b0 + 8); end
        if (a0_q.size() >= b0 + 8) begin
            for (int i = 0; i < 8; i++) begin
                checks++; if (a0_q[b0+i] !== 3'(i)) begin errors++; $display("FAIL full_addr[%0d]: got %0d expected %0d", i, a0_q[b0+i], i); end
                checks++; if (d0_q[b0+i] !== 24'h011000 + 24'(i)) begin errors++; $display("FAIL full_data[%0d]: got %h expected %h", i, d0_q[b0+i], 24'h011000 + 24'(i)); end
            end
        end
        checks++; if (log_full0 !== 1'b1) begin errors++; $display("FAIL full_flag: got %b expected 1", log_full0); end
        checks++; if (entry_count0 !== 4'd8) begin errors++; $display("FAIL full_count: got %0d expected 8", entry_count0); end
        checks++; if (overflow0 !== 1'b0) begin errors++; $display("FAIL full_no_overflow_yet: got %b expected 0", overflow0); end
        checks++; if (a1_q.size() !== b1 + 10) begin errors++; $display("FAIL wrap_strobes: got %0d expected %0d", a1_q.size(), b1 + 10); end
        if (a1_q.size() >= b1 + 10) begin
            for (int i = 0; i < 10; i++) begin
                checks++; if (a1_q[b1+i] !== 3'(i % 8)) begin errors++; $display("FAIL wrap_addr[%0d]: got %0d expected %0d", i, a1_q[b1+i], i % 8); end
                checks++; if (d1_q[b1+i] !== 24'h011000 + 24'(i)) begin errors++; $display("FAIL wrap_data[%0d]: got %h expected %h", i, d1_q[b1+i], 24'h011000 + 24'(i)); end
            end
        end
        checks++; if (entry_count1 !== 4'd8) begin errors++; $display("FAIL wrap_count: got %0d expected 8", entry_count1); end
        checks++; if (log_full1 !== 1'b1) begin errors++; $display("FAIL wrap_full: got %b expected 1", log_full1); end
        checks++; if (overflow1 !== 1'b0) begin errors++; $display("FAIL wrap_overflow: got %b expected 0", overflow1); end
        for (int i = 10; i < 12; i++) begin
            pulse(1'b1, 16'h1000 + 16'(i));
            tick(2);
        end
        checks++; if (overflow0 !== 1'b0) begin errors++; $display("FAIL halt_fifo_fill_no_drop: got %b expected 0", overflow0); end
        for (int i = 12; i < 14; i++) begin
            pulse(1'b1, 16'h1000 + 16'(i));
            tick(2);
        end
        checks++; if (overflow0 !== 1'b1) begin errors++; $display("FAIL halt_overflow: got %b expected 1", overflow0); end
        checks++; if (a0_q.size() !== b0 + 8) begin errors++; $display("FAIL halt_no_more_strobes: got %0d expected %0d", a0_q.size(), b0 + 8); end
        checks++; if (a1_q.size() !== b1 + 14) begin errors++; $display("FAIL wrap_keeps_writing: got %0d expected %0d", a1_q.size(), b1 + 14); end
        checks++; if (overflow1 !== 1'b0) begin errors++; $display("FAIL wrap_overflow_late: got %b expected 0", overflow1); end
        checks++; if (entry_count1 !== 4'd8) begin errors++; $display("FAIL wrap_count_saturated: got %0d expected 8", entry_count1); end
    endtask

    task automatic test_clear;
        int b0;
        b0 = a0_q.size();
        clear = 1'b1; ev_valid = 1'b1; ev_write = 1'b1; ev_addr = 16'hDEAD;
        tick(1);
        clear = 1'b0; ev_valid = 1'b0;
        checks++; if (entry_count0 !== 4'd0) begin errors++; $display("FAIL clear_count: got %0d expected 0", entry_count0); end
        checks++; if (log_full0 !== 1'b0) begin errors++; $display("FAIL clear_full: got %b expected 0", log_full0); end
        checks++; if (overflow0 !== 1'b0) begin errors++; $display("FAIL clear_overflow: got %b expected 0", overflow0); end
        checks++; if (log_wr0 !== 1'b0) begin errors++; $display("FAIL clear_log_wr: got %b expected 0", log_wr0); end
        checks++; if (entry_count1 !== 4'd0) begin errors++; $display("FAIL clear_count_wrap: got %0d expected 0", entry_count1); end
        checks++; if (log_full1 !== 1'b0) begin errors++; $display("FAIL clear_full_wrap: got %b expected 0", log_full1); end
        tick(3);
        checks++; if (a0_q.size() !== b0) begin errors++; $display("FAIL clear_flush_halted: got %0d expected %0d", a0_q.size(), b0); end
        log_busy = 1'b1;
        pulse(1'b0, 16'h0200);
        pulse(1'b0, 16'h0201);
        clear = 1'b1; ev_valid = 1'b1; ev_write = 1'b0; ev_addr = 16'h0202;
        tick(1);
        clear = 1'b0; ev_valid = 1'b0; log_busy = 1'b0;
        tick(4);
        checks++; if (a0_q.size() !== b0) begin errors++; $display("FAIL clear_collision_flush: got %0d expected %0d", a0_q.size(), b0); end
        checks++; if (entry_count0 !== 4'd0) begin errors++; $display("FAIL clear_collision_count: got %0d expected 0", entry_count0); end
        pulse(1'b1, 16'hBEEF);
        tick(2);
        checks++; if (a0_q.size() !== b0 + 1) begin errors++; $display("FAIL clear_next_strobe: got %0d expected %0d", a0_q.size(), b0 + 1); end
        if (a0_q.size() >= b0 + 1) begin
            checks++; if (a0_q[b0] !== 3'd0) begin errors++; $display("FAIL clear_next_addr: got %0d expected 0", a0_q[b0]); end
            checks++; if (d0_q[b0] !== 24'h01BEEF) begin errors++; $display("FAIL clear_next_data: got %h expected 01beef", d0_q[b0]); end
        end
        checks++; if (entry_count0 !== 4'd1) begin errors++; $display("FAIL clear_next_count: got %0d expected 1", entry_count0); end
    endtask

    task automatic test_enable;
        int b0;
        do_reset();
        enable = 1'b1;
        log_busy = 1'b1;
        b0 = a0_q.size();
        pulse(1'b0, 16'h0A00);
        pulse(1'b0, 16'h0A01);
        enable = 1'b0;
        for (int i = 0; i < 6; i++) begin
            pulse(1'b1, 16'h0B00 + 16'(i));
        end
        log_busy = 1'b0;
        tick(4);
        checks++; if (a0_q.size() !== b0 + 2) begin errors++; $display("FAIL enable_drain_count: got %0d expected %0d", a0_q.size(), b0 + 2); end
        if (a0_q.size() >= b0 + 2) begin
            checks++; if (d0_q[b0] !== 24'h020A00) begin errors++; $display("FAIL enable_data0: got %h expected 020a00", d0_q[b0]); end
            checks++; if (d0_q[b0+1] !== 24'h020A01) begin errors++; $display("FAIL enable_data1: got %h expected 020a01", d0_q[b0+1]); end
            checks++; if (a0_q[b0+1] !== 3'd1) begin errors++; $display("FAIL enable_addr1: got %0d expected 1", a0_q[b0+1]); end
        end
        checks++; if (overflow0 !== 1'b0) begin errors++; $display("FAIL enable_overflow: got %b expected 0", overflow0); end
        checks++; if (entry_count0 !== 4'd2) begin errors++; $display("FAIL enable_count: got %0d expected 2", entry_count0); end
    endtask

    task automatic test_reset_mid_burst;
        int b0;
        enable = 1'b1;
        log_busy = 1'b1;
        pulse(1'b0, 16'h0C00);
        pulse(1'b0, 16'h0C01);
        pulse(1'b0, 16'h0C02);
        b0 = a0_q.size();
        rst = 1'b1;
        log_busy = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(4);
        checks++; if (a0_q.size() !== b0) begin errors++; $display("FAIL rst_mid_no_strobe: got %0d expected %0d", a0_q.size(), b0); end
        checks++; if (entry_count0 !== 4'd0) begin errors++; $display("FAIL rst_mid_count: got %0d expected 0", entry_count0); end
        enable = 1'b1;
        pulse(1'b0, 16'h0D00);
        tick(2);
        checks++; if (a0_q.size() !== b0 + 1) begin errors++; $display("FAIL rst_mid_next_strobe: got %0d expected %0d", a0_q.size(), b0 + 1); end
        if (a0_q.size() >= b0 + 1) begin
            checks++; if (a0_q[b0] !== 3'd0) begin errors++; $display("FAIL rst_mid_next_addr: got %0d expected 0", a0_q[b0]); end
            checks++; if (d0_q[b0] !== 24'h020D00) begin errors++; $display("FAIL rst_mid_next_data: got %h expected 020d00", d0_q[b0]); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst_stall();
        test_full_and_wrap();
        test_clear();
        test_enable();
        test_reset_mid_burst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
